// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake, optional skid entry,
// flush-to-bubble and saturating stall/flush performance counters.
module pipe_stage_elastic #(
  parameter int unsigned        DATA_W = 96,
  parameter logic [DATA_W-1:0]  BUBBLE = {64'b0, 32'h00000013},
  parameter bit                 SKID   = 1'b1,
  parameter int unsigned        CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_deliver;
  logic              w_stall;
  logic              w_main_valid_nxt;
  logic [DATA_W-1:0] w_main_data_nxt;
  logic              w_skid_valid_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;

  // With a skid entry, in_ready comes straight from the skid valid flop,
  // so the downstream ready never reaches the upstream combinationally.
  assign w_in_ready = SKID ? !r_skid_valid : (!r_main_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_deliver  = r_main_valid && out_ready;
  assign w_stall    = r_main_valid && !out_ready;

  // Next-state for main and skid entries; flush overrides every transfer.
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_main_data_nxt  = r_main_data;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_main_data_nxt  = BUBBLE;
      w_skid_valid_nxt = 1'b0;
      w_skid_data_nxt  = BUBBLE;
    end else if (SKID) begin
      if (w_deliver) begin
        if (r_skid_valid) begin
          // in_ready is low while skid is full, so no accept can collide here
          w_main_valid_nxt = 1'b1;
          w_main_data_nxt  = r_skid_data;
          w_skid_valid_nxt = 1'b0;
          w_skid_data_nxt  = BUBBLE;
        end else if (w_accept) begin
          w_main_valid_nxt = 1'b1;
          w_main_data_nxt  = in_data;
        end else begin
          w_main_valid_nxt = 1'b0;
          w_main_data_nxt  = BUBBLE;
        end
      end else if (w_accept) begin
        if (!r_main_valid) begin
          w_main_valid_nxt = 1'b1;
          w_main_data_nxt  = in_data;
        end else begin
          w_skid_valid_nxt = 1'b1;
          w_skid_data_nxt  = in_data;
        end
      end
    end else begin
      if (w_accept) begin
        w_main_valid_nxt = 1'b1;
        w_main_data_nxt  = in_data;
      end else if (w_deliver) begin
        w_main_valid_nxt = 1'b0;
        w_main_data_nxt  = BUBBLE;
      end
    end
  end

  // Entry registers; reset loads the bubble payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_data  <= BUBBLE;
      r_skid_valid <= 1'b0;
      r_skid_data  <= BUBBLE;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_main_data  <= w_main_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
    end
  end

  // Saturating performance counters; a stalled flush cycle counts in both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: skid, non-skid and narrow-counter instances.
module tb_pipe_stage_elastic;

  localparam logic [95:0] BUB = {64'b0, 32'h00000013};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // SKID=1, 32-bit counters
  logic        v1, rdy1, or1, ov1, fl1;
  logic [95:0] d1, od1;
  logic [1:0]  oc1;
  logic [31:0] sc1, fc1;
  // SKID=0
  logic        v0, rdy0, or0, ov0, fl0;
  logic [95:0] d0, od0;
  logic [1:0]  oc0;
  logic [31:0] sc0, fc0;
  // SKID=1, 4-bit counters
  logic        vc, rdyc, orc, ovc, flc;
  logic [95:0] dc, odc;
  logic [1:0]  occ;
  logic [3:0]  scc, fcc;

  pipe_stage_elastic #(.DATA_W(96), .BUBBLE(BUB), .SKID(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .flush(fl1),
    .occupancy(oc1), .stall_cnt(sc1), .flush_cnt(fc1));

  pipe_stage_elastic #(.DATA_W(96), .BUBBLE(BUB), .SKID(1'b0), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .flush(fl0),
    .occupancy(oc0), .stall_cnt(sc0), .flush_cnt(fc0));

  pipe_stage_elastic #(.DATA_W(96), .BUBBLE(BUB), .SKID(1'b1), .CNT_W(4)) dutc (
    .clk(clk), .rst(rst), .in_valid(vc), .in_ready(rdyc), .in_data(dc),
    .out_valid(ovc), .out_ready(orc), .out_data(odc), .flush(flc),
    .occupancy(occ), .stall_cnt(scc), .flush_cnt(fcc));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    v1 = 0; or1 = 0; fl1 = 0; d1 = '0;
    v0 = 0; or0 = 0; fl0 = 0; d0 = '0;
    vc = 0; orc = 0; flc = 0; dc = '0;
    #1 rst = 1'b1;
    step(); step();
    chk("rst_ov",  ov1, 0);
    chk("rst_od",  od1, BUB);
    chk("rst_occ", oc1, 0);
    chk("rst_sc",  sc1, 0);
    chk("rst_fc",  fc1, 0);
    chk("rst_rdy", rdy1, 1);
    chk("rst_rdy0", rdy0, 1);
    rst = 1'b0;

    // streaming
    or1 = 1;
    for (int unsigned k = 1; k <= 8; k++) begin
      v1 = 1; d1 = 96'(k);
      #1 chk("str_rdy", rdy1, 1);
      step();
      chk("str_ov", ov1, 1);
      chk("str_od", od1, 128'(k));
    end
    v1 = 0;
    step();
    chk("str_empty", ov1, 0);
    chk("str_occ", oc1, 0);
    chk("str_sc", sc1, 0);

    // backpressure
    v1 = 1; d1 = 96'd1; step();
    or1 = 0; d1 = 96'd2; step();
    d1 = 96'd3;
    chk("bp_main", od1, 1);
    chk("bp_occ", oc1, 2);
    chk("bp_rdy", rdy1, 0);
    step();
    chk("bp_hold", od1, 1);
    chk("bp_sc2", sc1, 2);
    or1 = 1; step();
    chk("bp_d2", od1, 2);
    chk("bp_occ1", oc1, 1);
    chk("bp_rdy1", rdy1, 1);
    step();
    chk("bp_d3", od1, 3);
    v1 = 0; step();
    chk("bp_empty", ov1, 0);
    chk("bp_sc", sc1, 2);

    // flush while full, incoming payload 9 discarded
    v1 = 1; d1 = 96'd4; step();
    or1 = 0; d1 = 96'd5; step();
    chk("fl_occ2", oc1, 2);
    fl1 = 1; d1 = 96'd9; step();
    fl1 = 0; v1 = 0;
    chk("fl_ov", ov1, 0);
    chk("fl_lo", od1[31:0], 32'h13);
    chk("fl_od", od1, BUB);
    chk("fl_occ", oc1, 0);
    chk("fl_fc", fc1, 1);
    chk("fl_sc", sc1, 4);
    chk("fl_rdy", rdy1, 1);
    or1 = 1; v1 = 1; d1 = 96'd9; fl1 = 1; step();
    fl1 = 0;
    chk("fl_acc_occ", oc1, 0);
    chk("fl_acc_od", od1, BUB);
    chk("fl_fc2", fc1, 2);
    d1 = 96'd10; step();
    chk("fl_next", od1, 10);
    v1 = 0; step();
    chk("fl_drain", oc1, 0);

    // async reset mid-stream with occupancy 2
    or1 = 0; v1 = 1; d1 = 96'd11; step();
    d1 = 96'd12; step();
    v1 = 0;
    chk("ar_occ2", oc1, 2);
    #2 rst = 1'b1;
    #1;
    chk("ar_ov", ov1, 0);
    chk("ar_od", od1, BUB);
    chk("ar_occ", oc1, 0);
    chk("ar_sc", sc1, 0);
    chk("ar_fc", fc1, 0);
    chk("ar_rdy", rdy1, 1);
    step();
    rst = 1'b0;
    or1 = 1; v1 = 1; d1 = 96'd13; step();
    chk("ar_first", od1, 13);
    chk("ar_fov", ov1, 1);
    v1 = 0; step();

    // SKID=0 instance
    v0 = 1; d0 = 96'd21; or0 = 1; step();
    chk("s0_load", od0, 21);
    or0 = 0; d0 = 96'd22;
    #1 chk("s0_rdy0", rdy0, 0);
    step();
    chk("s0_hold", od0, 21);
    chk("s0_occ", oc0, 1);
    or0 = 1;
    #1 chk("s0_rdy1", rdy0, 1);
    step();
    chk("s0_d22", od0, 22);
    chk("s0_occ1", oc0, 1);
    v0 = 0; step();
    chk("s0_empty", oc0, 0);
    chk("s0_sc", sc0, 1);

    // counter saturation
    vc = 1; dc = 96'd7; orc = 0; step();
    vc = 0;
    for (int unsigned k = 0; k < 10; k++) step();
    chk("sat_10", scc, 10);
    for (int unsigned k = 0; k < 10; k++) step();
    chk("sat_15", scc, 15);
    chk("sat_od", odc, 7);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline stage register. It is the next generation of the fixed IF/ID register and will replace the fixed-width stall/flush registers between all five stages of the RV64I core. A valid/ready handshake replaces the bare enable. An optional skid entry breaks the combinational ready path. Flush inserts a configurable bubble payload, and saturating counters record stall and flush activity for performance analysis.

## Interface
- DATA_W, 96: payload width (the IF/ID instance uses {PC[63:0], Instr[31:0]}).
- BUBBLE, {64'b0, 32'h00000013}: payload shown while empty and loaded on reset/flush (NOP for IF/ID).
- SKID, 1: 1 = two-entry (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main entry holds a live payload.
- out_ready  in  1  downstream accepts this cycle (equivalent to !Stall of the next stage).
- out_data  out  DATA_W  main entry payload; equals BUBBLE whenever out_valid=0.
- flush  in  1  kill all held and incoming payloads (mispredict/redirect).
- occupancy  out  2  number of valid entries, 0..2 (max 1 when SKID=0).
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready; saturating.
- flush_cnt  out  CNT_W  cycles with flush=1; saturating.

## Operation
- Accept event: in_valid && in_ready. Deliver event: out_valid && out_ready.
- Storage: main entry (valid + data). With SKID=1 there is also a skid entry (valid + data). Payloads stay in order; skid is never newer-than-input-bypassed.
- SKID=0:
  - in_ready = !main_valid || out_ready.
  - An accept loads main. A deliver without an accept clears main to BUBBLE/invalid.
- SKID=1:
  - in_ready = !skid_valid, taken directly from a flop.
  - Accept while main is empty, or while main is delivering and skid is empty: the input goes to main.
  - Accept while main is full and not delivering: the input goes to skid.
  - Deliver while skid is full: skid moves to main and skid is cleared.
  - Deliver with skid empty and no accept: main is cleared.
- Flush has priority over everything:
  - Next cycle, main and skid are invalid and their data is BUBBLE.
  - Any same-cycle accept is discarded.
  - in_ready is not gated by flush.
  - The deliver event in the flush cycle still counts as delivered downstream.
- Counters:
  - Each counter increments by 1 per qualifying cycle and holds at all-ones.
  - A flush cycle with a stalled output counts in both counters.
- out_data is the main data register only, with no mux on the output path; bubble insertion happens at load time.

## Timing
- Reset (asynchronous, held until deassert):
  - out_valid=0, out_data=BUBBLE, occupancy=0, stall_cnt=0, flush_cnt=0.
  - Skid is invalid.
  - in_ready=1 (both SKID settings).
- Latency: accept in cycle N gives out_valid=1 with that payload in cycle N+1.
- Throughput: 1 payload/cycle sustained when out_ready=1.
- SKID=1 backpressure:
  - out_ready drops while main is full: one further payload is accepted into skid, and in_ready=0 from the next cycle.
  - After out_ready returns, in_ready=1 in the cycle following the first deliver.
  - No payload is lost or duplicated.
- Full plus simultaneous accept and deliver (SKID=1, both entries full):
  - in_ready=0, so there is no accept.
  - Skid moves to main. Occupancy goes 2→1.
- Empty: out_valid=0, and a deliver cannot occur regardless of out_ready.
- Flush in cycle N: occupancy=0 and out_data=BUBBLE in N+1. A new accept is possible in N+1.
- Reset asserted mid-transfer: state goes immediately to reset values. The first accept is possible in the first cycle after deassert.

## Test plan
- Streaming: SKID=1, out_ready=1, payloads 1..8 on consecutive cycles. Required: out_data 1..8 in cycles 2..9, in_ready always 1, stall_cnt=0.
- Backpressure: send 1,2,3 back-to-back with out_ready=0 from cycle 2. Required:
  - main=1, skid=2, occupancy=2, in_ready=0, and 3 is held upstream.
  - After out_ready=1, delivery order is 1,2,3.
  - stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- Flush while full: occupancy=2, assert flush with in_valid=1 (payload 9). Required:
  - Next cycle: out_valid=0, out_data=32'h00000013 in the low bits, occupancy=0, flush_cnt=1.
  - Payload 9 never appears.
- SKID=0 instance: out_ready=0 with main full. Required: in_ready=0 in the same cycle. With out_ready=1 and in_valid=1, a simultaneous accept and deliver keeps occupancy=1.
- Asynchronous reset mid-stream: assert rst between clock edges with occupancy=2. Required: all outputs at reset values before the next edge, and counters at 0.
- Counter saturation: CNT_W=4 with 20 stalled cycles. Required: stall_cnt holds at 15.
